// File: rtl/jtgng_obj_pkg.sv
// Shared definitions for the object line scanner: scan states and the
// default byte written into unused line-buffer slots.
package jtgng_obj_pkg;

  typedef enum logic [2:0] {
    OBJ_IDLE,
    OBJ_SEARCH,
    OBJ_WAIT,
    OBJ_COPY,
    OBJ_FILL,
    OBJ_DONE
  } obj_state_t;

  localparam logic [7:0] OBJ_FILLV = 8'hF8;

endpackage

// File: rtl/jtgng_ram.sv
// Single-port synchronous RAM with clock enable; read data registered,
// read-before-write on a simultaneous access.
module jtgng_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          cen,
  input  logic [dw-1:0] data,
  input  logic [aw-1:0] addr,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem [0:2**aw-1];

  always_ff @(posedge clk) begin
    if (cen) begin
      if (we) mem[addr] <= data;
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/jtgng_objscan.sv
// Per-line object table scanner: copies objects visible on the next line
// into a double-buffered line RAM, padding unused slots with FILLV.
module jtgng_objscan
  import jtgng_obj_pkg::*;
#(
  parameter int         AW      = 9,
  parameter int         OBJB    = 2,
  parameter int         BUFN    = 5,
  parameter int         LIMIT   = 24,
  parameter int         OBJMAX  = 96,
  parameter int         YBYTE   = 2,
  parameter int         YOFF    = 3,
  parameter int         HEIGHT  = 16,
  parameter logic [7:0] FILLV   = OBJ_FILLV,
  parameter int         REVERSE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            hinit,
  input  logic            lvbl,
  input  logic [7:0]      v,
  input  logic            flip,
  output logic [AW-1:0]   scan_addr,
  input  logic [7:0]      scan_data,
  input  logic [BUFN-1:0] rd_obj,
  input  logic [OBJB-1:0] rd_byte,
  output logic [7:0]      rd_data,
  output logic [7:0]      vf,
  output logic            line,
  output logic [BUFN:0]   obj_cnt,
  output logic            overflow,
  output logic            late
);

  localparam int              OW        = AW - OBJB;
  localparam int              SW        = BUFN + OBJB;
  localparam logic [OW-1:0]   LAST_OBJ  = OW'(OBJMAX - 1);
  localparam logic [BUFN:0]   LIM       = (BUFN + 1)'(LIMIT);
  localparam logic [OBJB-1:0] LAST_BYTE = '1;
  localparam logic [OBJB-1:0] YB        = OBJB'(YBYTE);
  localparam logic [AW-1:0]   Y0        = {{OW{1'b0}}, YB};
  localparam logic [7:0]      YOFF8     = 8'(YOFF);
  localparam logic [7:0]      HEIGHT8   = 8'(HEIGHT);

  function automatic logic [BUFN-1:0] slot_of(input logic [BUFN:0] k);
    if (REVERSE != 0) return BUFN'(LIMIT - 1) - k[BUFN-1:0];
    else              return k[BUFN-1:0];
  endfunction

  obj_state_t      state, state_nxt;
  logic            copying, copying_nxt;
  logic [OW-1:0]   obj_idx, obj_nxt, obj_inc;
  logic [OBJB-1:0] byte_idx, byte_nxt, byte_inc;
  logic [BUFN:0]   n_q, n_nxt, fslot, fslot_nxt;
  logic            addr_stable, stable_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [7:0]      vf_nxt;
  logic            line_nxt, ovf_nxt, late_nxt;
  logic [BUFN:0]   cnt_nxt;
  logic            wr_en;
  logic [SW-1:0]   wr_addr, rd_addr;
  logic [7:0]      wr_data, ydist, q0, q1;
  logic            hit, rd_bank;

  assign obj_inc  = obj_idx + 1'b1;
  assign byte_inc = byte_idx + 1'b1;
  assign ydist    = vf + YOFF8 - scan_data;
  assign hit      = ydist < HEIGHT8;
  assign rd_addr  = {rd_obj, rd_byte};

  always_comb begin
    state_nxt   = state;
    copying_nxt = copying;
    obj_nxt     = obj_idx;
    byte_nxt    = byte_idx;
    n_nxt       = n_q;
    fslot_nxt   = fslot;
    addr_nxt    = scan_addr;
    vf_nxt      = vf;
    line_nxt    = line;
    cnt_nxt     = obj_cnt;
    ovf_nxt     = 1'b0;
    late_nxt    = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = scan_data;
    case (state)
      OBJ_IDLE, OBJ_DONE: addr_nxt = Y0;
      OBJ_SEARCH: begin
        // scan_data is trusted only once scan_addr has held for a full cen
        if (addr_stable) begin
          if (hit) begin
            copying_nxt = 1'b1;
            byte_nxt    = '0;
            addr_nxt    = {obj_idx, {OBJB{1'b0}}};
            state_nxt   = OBJ_WAIT;
          end else if (obj_idx == LAST_OBJ) begin
            fslot_nxt = n_q;
            byte_nxt  = '0;
            state_nxt = OBJ_FILL;
          end else begin
            obj_nxt   = obj_inc;
            addr_nxt  = {obj_inc, YB};
            state_nxt = OBJ_WAIT;
          end
        end
      end
      OBJ_WAIT: state_nxt = copying ? OBJ_COPY : OBJ_SEARCH;
      OBJ_COPY: begin
        wr_en   = 1'b1;
        wr_addr = {slot_of(n_q), byte_idx};
        if (byte_idx != LAST_BYTE) begin
          byte_nxt  = byte_inc;
          addr_nxt  = {obj_idx, byte_inc};
          state_nxt = OBJ_WAIT;
        end else begin
          n_nxt       = n_q + 1'b1;
          copying_nxt = 1'b0;
          if (n_nxt == LIM && obj_idx != LAST_OBJ) begin
            ovf_nxt   = 1'b1;
            addr_nxt  = Y0;
            state_nxt = OBJ_DONE;
          end else if (obj_idx == LAST_OBJ) begin
            fslot_nxt = n_nxt;
            byte_nxt  = '0;
            state_nxt = OBJ_FILL;
          end else begin
            obj_nxt   = obj_inc;
            addr_nxt  = {obj_inc, YB};
            state_nxt = OBJ_WAIT;
          end
        end
      end
      OBJ_FILL: begin
        if (fslot >= LIM) begin
          addr_nxt  = Y0;
          state_nxt = OBJ_DONE;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = {slot_of(fslot), byte_idx};
          wr_data  = FILLV;
          byte_nxt = byte_inc;
          if (byte_idx == LAST_BYTE) fslot_nxt = fslot + 1'b1;
        end
      end
      default: state_nxt = OBJ_IDLE;
    endcase
    // Line start overrides the scan but lets this cycle's write land first.
    if (hinit) begin
      late_nxt    = (state != OBJ_IDLE) && (state != OBJ_DONE);
      vf_nxt      = v ^ {8{flip}};
      line_nxt    = ~line;
      cnt_nxt     = n_nxt;
      n_nxt       = '0;
      obj_nxt     = '0;
      byte_nxt    = '0;
      fslot_nxt   = '0;
      copying_nxt = 1'b0;
      addr_nxt    = Y0;
      state_nxt   = lvbl ? OBJ_SEARCH : OBJ_IDLE;
    end
    stable_nxt = (addr_nxt == scan_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= OBJ_IDLE;
      copying     <= 1'b0;
      obj_idx     <= '0;
      byte_idx    <= '0;
      n_q         <= '0;
      fslot       <= '0;
      addr_stable <= 1'b0;
      scan_addr   <= '0;
      vf          <= '0;
      line        <= 1'b0;
      obj_cnt     <= '0;
      overflow    <= 1'b0;
      late        <= 1'b0;
      rd_bank     <= 1'b0;
    end else if (cen) begin
      state       <= state_nxt;
      copying     <= copying_nxt;
      obj_idx     <= obj_nxt;
      byte_idx    <= byte_nxt;
      n_q         <= n_nxt;
      fslot       <= fslot_nxt;
      addr_stable <= stable_nxt;
      scan_addr   <= addr_nxt;
      vf          <= vf_nxt;
      line        <= line_nxt;
      obj_cnt     <= cnt_nxt;
      overflow    <= ovf_nxt;
      late        <= late_nxt;
      rd_bank     <= ~line;
    end
  end

  jtgng_ram #(.dw(8), .aw(SW)) u_bank0 (
    .clk  (clk),
    .cen  (cen),
    .data (wr_data),
    .addr (line ? rd_addr : wr_addr),
    .we   (wr_en & ~line & rst_n),
    .q    (q0)
  );

  jtgng_ram #(.dw(8), .aw(SW)) u_bank1 (
    .clk  (clk),
    .cen  (cen),
    .data (wr_data),
    .addr (line ? wr_addr : rd_addr),
    .we   (wr_en & line & rst_n),
    .q    (q1)
  );

  assign rd_data = rd_bank ? q1 : q0;

endmodule

// File: tb/tb_jtgng_objscan.sv
// Directed bench for jtgng_objscan: default instance plus a REVERSE=0 instance
// sharing stimulus, each fed by a registered model of the object table.
module tb_jtgng_objscan;

  logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
  logic       hinit = 1'b0, lvbl = 1'b0, flip = 1'b0;
  logic [7:0] v = '0;
  logic [4:0] rd_obj = '0;
  logic [1:0] rd_byte = '0;

  logic [8:0] scan_addr, scan_addr2;
  logic [7:0] scan_data, scan_data2;
  logic [7:0] rd_data, rd_data2, vf, vf2;
  logic       line, line2, overflow, overflow2, late, late2;
  logic [5:0] obj_cnt, obj_cnt2;

  logic [7:0] tbl [0:511];
  int checks = 0;
  int errors = 0;
  int ovf_seen;

  jtgng_objscan dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .hinit(hinit), .lvbl(lvbl), .v(v),
    .flip(flip), .scan_addr(scan_addr), .scan_data(scan_data),
    .rd_obj(rd_obj), .rd_byte(rd_byte), .rd_data(rd_data), .vf(vf),
    .line(line), .obj_cnt(obj_cnt), .overflow(overflow), .late(late)
  );

  jtgng_objscan #(.REVERSE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .hinit(hinit), .lvbl(lvbl), .v(v),
    .flip(flip), .scan_addr(scan_addr2), .scan_data(scan_data2),
    .rd_obj(rd_obj), .rd_byte(rd_byte), .rd_data(rd_data2), .vf(vf2),
    .line(line2), .obj_cnt(obj_cnt2), .overflow(overflow2), .late(late2)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen = ~cen;

  always @(posedge clk) begin
    if (cen) begin
      scan_data  <= tbl[scan_addr];
      scan_data2 <= tbl[scan_addr2];
    end
  end

  task automatic cen_cycle();
    do @(posedge clk); while (!cen);
    #1;
  endtask

  task automatic cens(input int n);
    for (int i = 0; i < n; i++) cen_cycle();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_table(input logic [7:0] yfill);
    for (int a = 0; a < 512; a++) begin
      logic [8:0] a9;
      a9 = 9'(a);
      tbl[a] = (a9[1:0] == 2'd2) ? yfill : a9[7:0];
    end
  endtask

  task automatic pulse_hinit(input logic [7:0] vv, input logic lv, input logic fl);
    v = vv; lvbl = lv; flip = fl; hinit = 1'b1;
    cen_cycle();
    hinit = 1'b0;
  endtask

  task automatic rd(input int slot, input int b);
    rd_obj  = 5'(slot);
    rd_byte = 2'(b);
    cen_cycle();
  endtask

  initial begin
    set_table(8'hA0);
    cens(3);
    chk("rst_line", 32'(line), 0);
    chk("rst_vf", 32'(vf), 0);
    chk("rst_addr", 32'(scan_addr), 0);
    chk("rst_cnt", 32'(obj_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_late", 32'(late), 0);
    rst_n = 1'b1;
    cens(2);
    chk("idle_addr", 32'(scan_addr), 2);

    // single object at index 5, y=0x38, line 0x40
    set_table(8'hA0);
    tbl[22] = 8'h38;
    pulse_hinit(8'h40, 1'b1, 1'b0);
    chk("a_vf", 32'(vf), 32'h40);
    chk("a_line", 32'(line), 1);
    chk("a_late0", 32'(late), 0);
    cens(450);
    pulse_hinit(8'h00, 1'b0, 1'b0);
    chk("a_late", 32'(late), 0);
    chk("a_line2", 32'(line), 0);
    chk("a_cnt", 32'(obj_cnt), 1);
    rd(23, 0); chk("a_s23b0", 32'(rd_data), 20);
    rd(23, 1); chk("a_s23b1", 32'(rd_data), 21);
    rd(23, 2); chk("a_s23b2", 32'(rd_data), 32'h38);
    rd(23, 3); chk("a_s23b3", 32'(rd_data), 23);
    rd(22, 3); chk("a_s22b3", 32'(rd_data), 32'hF8);
    rd(0, 0);  chk("a_s0b0", 32'(rd_data), 32'hF8);

    // wrap-around: y=0xFE hits, y=0x13 misses at vf=0x02 (flipped 0xFD)
    set_table(8'hA0);
    tbl[42] = 8'hFE;
    tbl[46] = 8'h13;
    pulse_hinit(8'hFD, 1'b1, 1'b1);
    chk("b_vf", 32'(vf), 32'h02);
    cens(450);
    pulse_hinit(8'h00, 1'b0, 1'b0);
    chk("b_cnt", 32'(obj_cnt), 1);
    rd(23, 2); chk("b_s23b2", 32'(rd_data), 32'hFE);
    rd(23, 0); chk("b_s23b0", 32'(rd_data), 40);
    rd(22, 2); chk("b_s22b2", 32'(rd_data), 32'hF8);

    // hits at objects 3 and 7, both slot orders
    set_table(8'hA0);
    tbl[14] = 8'h40;
    tbl[30] = 8'h40;
    pulse_hinit(8'h40, 1'b1, 1'b0);
    cens(450);
    pulse_hinit(8'h00, 1'b0, 1'b0);
    chk("e_cnt", 32'(obj_cnt), 2);
    chk("e_cnt2", 32'(obj_cnt2), 2);
    rd(0, 0);  chk("e2_s0", 32'(rd_data2), 12);
               chk("e_s0", 32'(rd_data), 32'hF8);
    rd(1, 0);  chk("e2_s1", 32'(rd_data2), 28);
    rd(2, 0);  chk("e2_s2", 32'(rd_data2), 32'hF8);
    rd(23, 0); chk("e_s23", 32'(rd_data), 12);
    rd(22, 0); chk("e_s22", 32'(rd_data), 28);

    // 30 hitting objects overflow the 24-slot buffer
    set_table(8'hA0);
    for (int i = 0; i < 30; i++) tbl[i*4+2] = 8'h40;
    pulse_hinit(8'h40, 1'b1, 1'b0);
    ovf_seen = 0;
    for (int i = 0; i < 450; i++) begin
      cen_cycle();
      if (overflow) ovf_seen++;
    end
    chk("c_ovf_pulses", 32'(ovf_seen), 1);
    pulse_hinit(8'h00, 1'b0, 1'b0);
    chk("c_cnt", 32'(obj_cnt), 24);
    chk("c_late", 32'(late), 0);
    rd(0, 0);  chk("c_s0b0", 32'(rd_data), 92);
    rd(0, 1);  chk("c_s0b1", 32'(rd_data), 93);
    rd(12, 0); chk("c_s12b0", 32'(rd_data), 44);
    rd(23, 1); chk("c_s23b1", 32'(rd_data), 1);

    // line start arriving while object 0 is being copied
    pulse_hinit(8'h40, 1'b1, 1'b0);
    chk("d_line1", 32'(line), 1);
    cens(2);
    pulse_hinit(8'h40, 1'b1, 1'b0);
    chk("d_late", 32'(late), 1);
    chk("d_line", 32'(line), 0);
    chk("d_addr", 32'(scan_addr), 2);
    cen_cycle();
    chk("d_late_end", 32'(late), 0);

    // reset in the middle of a scan
    pulse_hinit(8'h40, 1'b1, 1'b0);
    cens(2);
    rst_n = 1'b0;
    cen_cycle();
    chk("f_line", 32'(line), 0);
    chk("f_vf", 32'(vf), 0);
    chk("f_addr", 32'(scan_addr), 0);
    chk("f_cnt", 32'(obj_cnt), 0);
    chk("f_ovf", 32'(overflow), 0);
    chk("f_late", 32'(late), 0);
    rst_n = 1'b1;
    pulse_hinit(8'h55, 1'b0, 1'b0);
    chk("f_idle_late", 32'(late), 0);
    chk("f_idle_vf", 32'(vf), 32'h55);
    cens(4);
    chk("f_idle_addr", 32'(scan_addr), 2);
    chk("f_idle_ovf", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
